dmem_responder: RTL and testbench

- Data-memory slave and two-master arbiter on the CPU data bus.
- Accepts read/write requests from the core load/store path (master 0) and the stack unit (master 1).
- Serialises the requests into an internal synchronous RAM.
- Returns a one-cycle grant per completed access; read data is valid in that grant cycle.
- It is the responder end of the req/grant handshake used by the stack push/pop sequencer.

---
 rtl/dmem_responder_pkg.sv | 27 ++
 rtl/dmem_ram.sv | 55 +++++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared encodings for the data-memory responder: FSM states,
//               bus owner identifiers and bus operation codes.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

  // Responder FSM states
  typedef enum logic [0:0] {
    DMEM_IDLE   = 1'b0,
    DMEM_ACCESS = 1'b1
  } dmem_state_e;

  // Bus masters; the encoding doubles as the grant index
  typedef enum logic [0:0] {
    OWNER_CORE  = 1'b0,
    OWNER_STACK = 1'b1
  } dmem_owner_e;

  // Bus operation carried on the *_wr select line
  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

endpackage : dmem_responder_pkg
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ram
// Description : Single-port synchronous RAM with registered read data.
//               Accesses at or above DEPTH are dropped (write) or return
//               zero (read).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ram #(
  parameter int    ADDR_W    = 8,
  parameter int    DATA_W    = 8,
  parameter int    DEPTH     = 256,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  // Index width into the storage array; a one-word RAM still needs one bit
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH may equal 2**ADDR_W, so compare in ADDR_W+1 bits
  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;

  assign w_in_range = ({1'b0, addr_i} < c_DEPTH);
  assign w_idx      = addr_i[IDX_W-1:0];
  assign rdata_o    = rdata_q;

  // Storage write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we_i && w_in_range) begin
      mem_q[w_idx] <= wdata_i;
    end
  end

  // Registered read port; out-of-range reads return zero
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= w_in_range ? mem_q[w_idx] : '0;
    end
  end

endmodule : dmem_ram
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory slave with a two-master arbiter. Master 0 is the
//               core load/store path, master 1 the stack unit. Each access
//               takes two cycles: IDLE (arbitrate + RAM op at the edge) and
//               ACCESS (single-cycle grant to the owner, read data valid).
// Config      : DMEM_RR_ARB_EN - when defined, simultaneous requests are
//               resolved round-robin (the master that was not last served
//               wins); otherwise the stack unit has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int    ADDR_W    = 8,
  parameter int    DATA_W    = 8,
  parameter int    DEPTH     = 256,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_grant,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_grant,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

`ifdef DMEM_RR_ARB_EN
  localparam logic c_RR_EN = 1'b1;
`else
  localparam logic c_RR_EN = 1'b0;
`endif

  dmem_state_e       state_q, state_d;
  dmem_owner_e       owner_q, owner_d;
  dmem_owner_e       last_owner_q, last_owner_d;
  dmem_owner_e       win_d;

  logic              ram_we_d;
  logic              ram_re_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_d;
  logic              sel_wr_d;

  // Pick the winning master for the current IDLE cycle
  always_comb begin
    win_d = OWNER_CORE;
    if (c_RR_EN && m0_req && m1_req) begin
      win_d = (last_owner_q == OWNER_STACK) ? OWNER_CORE : OWNER_STACK;
    end else if (m1_req) begin
      win_d = OWNER_STACK;
    end else begin
      win_d = OWNER_CORE;
    end
  end

  // FSM state, current owner and last-served owner registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= DMEM_IDLE;
      owner_q      <= OWNER_CORE;
      last_owner_q <= OWNER_STACK;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Next-state, RAM command and grant decode
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    ram_we_d     = 1'b0;
    ram_re_d     = 1'b0;
    ram_addr_d   = m0_addr;
    ram_wdata_d  = m0_wdata;
    sel_wr_d     = READ;
    m0_grant     = 1'b0;
    m1_grant     = 1'b0;
    busy         = 1'b0;

    case (state_q)
      DMEM_IDLE: begin
        if (m0_req || m1_req) begin
          owner_d = win_d;
          if (win_d == OWNER_STACK) begin
            ram_addr_d  = m1_addr;
            ram_wdata_d = m1_wdata;
            sel_wr_d    = m1_wr;
          end else begin
            ram_addr_d  = m0_addr;
            ram_wdata_d = m0_wdata;
            sel_wr_d    = m0_wr;
          end
          // A reset on this edge must not corrupt memory
          ram_we_d = (sel_wr_d == WRITE) && !rst;
          ram_re_d = (sel_wr_d == READ);
          state_d  = DMEM_ACCESS;
        end
      end

      DMEM_ACCESS: begin
        busy         = 1'b1;
        m0_grant     = (owner_q == OWNER_CORE);
        m1_grant     = (owner_q == OWNER_STACK);
        last_owner_d = owner_q;
        state_d      = DMEM_IDLE;
      end

      default: begin
        state_d = DMEM_IDLE;
      end
    endcase
  end

  dmem_ram #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we_d),
    .re_i    (ram_re_d),
    .addr_i  (ram_addr_d),
    .wdata_i (ram_wdata_d),
    .rdata_o (rdata)
  );

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder. A second
//               instance with DEPTH=128 shares the stimulus and is used for
//               the out-of-range cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic       clk;
  logic       rst;
  logic       m0_req, m0_wr, m1_req, m1_wr;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

  logic       m0_grant_a, m1_grant_a, busy_a;
  logic [7:0] rdata_a;
  logic       m0_grant_b, m1_grant_b, busy_b;
  logic [7:0] rdata_b;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .INIT_FILE("")) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_grant(m0_grant_a),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_grant(m1_grant_a),
    .rdata(rdata_a), .busy(busy_a)
  );

  dmem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .INIT_FILE("")) u_dut128 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_grant(m0_grant_b),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_grant(m1_grant_b),
    .rdata(rdata_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int m, input logic wr, input logic [7:0] a, input logic [7:0] d);
    if (m == 1) begin
      m1_req = 1'b1; m1_wr = wr; m1_addr = a; m1_wdata = d;
    end else begin
      m0_req = 1'b1; m0_wr = wr; m0_addr = a; m0_wdata = d;
    end
  endtask

  // One isolated access; returns at the falling edge of the grant cycle
  task automatic do_acc(input string tag, input int m, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input logic chk_rd, input logic [7:0] exp_rd);
    @(posedge clk); #1;
    drive(m, wr, a, d);
    @(negedge clk);
    chk_val({tag, "_pre_gnt"}, {30'd0, m1_grant_a, m0_grant_a}, 32'd0);
    @(negedge clk);
    chk_val({tag, "_gnt"}, {30'd0, m1_grant_a, m0_grant_a}, (m == 1) ? 32'd2 : 32'd1);
    chk_val({tag, "_busy"}, {31'd0, busy_a}, 32'd1);
    if (chk_rd) chk_val({tag, "_rdata"}, {24'd0, rdata_a}, {24'd0, exp_rd});
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_wr = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00;
    m1_req = 1'b0; m1_wr = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_val("rst_grants", {30'd0, m1_grant_a, m0_grant_a}, 32'd0);
    chk_val("rst_rdata", {24'd0, rdata_a}, 32'd0);
    chk_val("rst_busy", {31'd0, busy_a}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Core write then read back
    do_acc("m0_wr10", 0, 1'b1, 8'h10, 8'h5A, 1'b0, 8'h00);
    do_acc("m0_rd10", 0, 1'b0, 8'h10, 8'h00, 1'b1, 8'h5A);

    // Stack push with request held across both accesses
    @(posedge clk); #1 drive(1, 1'b1, 8'hFE, 8'h07);
    @(negedge clk); chk_val("push_pre", {30'd0, m1_grant_a, m0_grant_a}, 32'd0);
    @(negedge clk); chk_val("push1_gnt", {30'd0, m1_grant_a, m0_grant_a}, 32'd2);
    drive(1, 1'b1, 8'hFD, 8'h42);
    @(negedge clk); chk_val("push_gap", {29'd0, busy_a, m1_grant_a, m0_grant_a}, 32'd0);
    @(negedge clk); chk_val("push2_gnt", {30'd0, m1_grant_a, m0_grant_a}, 32'd2);
    m1_req = 1'b0;

    // Stack pop with request held
    @(posedge clk); #1 drive(1, 1'b0, 8'hFD, 8'h00);
    @(negedge clk); chk_val("pop_pre", {30'd0, m1_grant_a, m0_grant_a}, 32'd0);
    @(negedge clk); chk_val("pop1_gnt", {30'd0, m1_grant_a, m0_grant_a}, 32'd2);
    chk_val("pop1_rdata", {24'd0, rdata_a}, 32'h42);
    drive(1, 1'b0, 8'hFE, 8'h00);
    @(negedge clk); chk_val("pop_gap", {30'd0, m1_grant_a, m0_grant_a}, 32'd0);
    @(negedge clk); chk_val("pop2_gnt", {30'd0, m1_grant_a, m0_grant_a}, 32'd2);
    chk_val("pop2_rdata", {24'd0, rdata_a}, 32'h07);
    m1_req = 1'b0;

    // Simultaneous requests
    do_acc("pre20", 0, 1'b1, 8'h20, 8'hA0, 1'b0, 8'h00);
    do_acc("pre21", 1, 1'b1, 8'h21, 8'hB1, 1'b0, 8'h00);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h20, 8'h00);
    drive(1, 1'b0, 8'h21, 8'h00);
    @(negedge clk); chk_val("tie_pre", {30'd0, m1_grant_a, m0_grant_a}, 32'd0);
    @(negedge clk);
`ifdef DMEM_RR_ARB_EN
    chk_val("tie_first_gnt", {30'd0, m1_grant_a, m0_grant_a}, 32'd1);
    chk_val("tie_first_rdata", {24'd0, rdata_a}, 32'hA0);
    m0_req = 1'b0;
`else
    chk_val("tie_first_gnt", {30'd0, m1_grant_a, m0_grant_a}, 32'd2);
    chk_val("tie_first_rdata", {24'd0, rdata_a}, 32'hB1);
    m1_req = 1'b0;
`endif
    @(negedge clk); chk_val("tie_gap", {30'd0, m1_grant_a, m0_grant_a}, 32'd0);
    @(negedge clk);
`ifdef DMEM_RR_ARB_EN
    chk_val("tie_second_gnt", {30'd0, m1_grant_a, m0_grant_a}, 32'd2);
    chk_val("tie_second_rdata", {24'd0, rdata_a}, 32'hB1);
`else
    chk_val("tie_second_gnt", {30'd0, m1_grant_a, m0_grant_a}, 32'd1);
    chk_val("tie_second_rdata", {24'd0, rdata_a}, 32'hA0);
`endif
    m0_req = 1'b0;
    m1_req = 1'b0;

    // Reset during ACCESS of a core read
    do_acc("pre40", 0, 1'b1, 8'h40, 8'h3C, 1'b0, 8'h00);
    @(posedge clk); #1 drive(0, 1'b0, 8'h40, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    m0_req = 1'b0;
    @(negedge clk); chk_val("rstacc_rdata_before", {24'd0, rdata_a}, 32'h3C);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_val("rstacc_gnt", {30'd0, m1_grant_a, m0_grant_a}, 32'd0);
    chk_val("rstacc_rdata", {24'd0, rdata_a}, 32'd0);
    chk_val("rstacc_busy", {31'd0, busy_a}, 32'd0);

    // Reset in IDLE with a pending stack write must not touch memory
    do_acc("pre30", 1, 1'b1, 8'h30, 8'h11, 1'b0, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1, 1'b1, 8'h30, 8'hEE);
    @(posedge clk); #1;
    rst = 1'b0;
    m1_req = 1'b0;
    @(negedge clk); chk_val("rstidle_gnt", {30'd0, m1_grant_a, m0_grant_a}, 32'd0);
    do_acc("rstidle_rd30", 1, 1'b0, 8'h30, 8'h00, 1'b1, 8'h11);

    // Out-of-range handling on the DEPTH=128 instance
    do_acc("oor_pre00", 0, 1'b1, 8'h00, 8'h55, 1'b0, 8'h00);
    do_acc("oor_wr80", 0, 1'b1, 8'h80, 8'h99, 1'b0, 8'h00);
    chk_val("oor_wr80_gnt128", {30'd0, m1_grant_b, m0_grant_b}, 32'd1);
    do_acc("oor_rd80", 0, 1'b0, 8'h80, 8'h00, 1'b1, 8'h99);
    chk_val("oor_rd80_gnt128", {30'd0, m1_grant_b, m0_grant_b}, 32'd1);
    chk_val("oor_rd80_rdata128", {24'd0, rdata_b}, 32'd0);
    do_acc("oor_rd00", 0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h55);
    chk_val("oor_rd00_rdata128", {24'd0, rdata_b}, 32'h55);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dmem_responder
`default_nettype wire
